// File: rtl/coeff_mult_pipe.sv
// -----------------------------------------------------------------------------
// coeff_mult_pipe
//
// Pipelined multi-coefficient constant multiplier. Each accepted sample is
// multiplied by one of NUM_COEFFS compile-time coefficients selected per
// sample. The exact product is then rounded half-up, arithmetically shifted
// right by SHIFT and saturated to OUTPUT_WIDTH. A sideband tag travels with
// each sample unmodified.
//
// Pipeline (all stages advance together, or all freeze on a stall):
//   S1  capture sample, tag and the selected coefficient
//   S2  full-precision multiply
//   S3  round / shift / saturate; S3 drives the output port directly
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   input sample valid
//   in_ready_o   block can accept a sample this cycle (combinational)
//   data_i       input sample
//   coeff_idx_i  coefficient select; out-of-range selects a coefficient of 0
//   tag_i        sideband, returned unmodified with the result
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   product_o    rounded / shifted / saturated product
//   tag_o        tag aligned with product_o
//   sat_o        this result was clipped
//   sat_count_o  saturating count of clipped results delivered
//   clear_i      synchronous clear of sat_count_o (wins over an increment)
// -----------------------------------------------------------------------------
module coeff_mult_pipe #(
   parameter int unsigned INPUT_WIDTH  = 10,
   parameter int unsigned COEFF_WIDTH  = 10,
   parameter int unsigned OUTPUT_WIDTH = 10,
   parameter int unsigned NUM_COEFFS   = 4,
   // Packed table: coefficient k lives at COEFFS[k*COEFF_WIDTH +: COEFF_WIDTH]
   parameter logic [NUM_COEFFS*COEFF_WIDTH-1:0] COEFFS = {10'd100, 10'd7, -10'sd3, 10'd1},
   parameter int unsigned SHIFT        = 0,
   parameter int unsigned SIGNED       = 1,
   parameter int unsigned TAG_WIDTH    = 2,
   parameter int unsigned COUNT_WIDTH  = 8,
   localparam int unsigned IDX_WIDTH   = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [INPUT_WIDTH-1:0]  data_i,
   input  logic [IDX_WIDTH-1:0]    coeff_idx_i,
   input  logic [TAG_WIDTH-1:0]    tag_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [OUTPUT_WIDTH-1:0] product_o,
   output logic [TAG_WIDTH-1:0]    tag_o,
   output logic                    sat_o,
   output logic [COUNT_WIDTH-1:0]  sat_count_o,
   input  logic                    clear_i
);

   // Exact product width, plus two guard bits so that sign/zero extension and
   // the rounding add can never wrap, whatever the signedness.
   localparam int unsigned ProdWidth = INPUT_WIDTH + COEFF_WIDTH;
   localparam int unsigned ExtWidth  = ProdWidth + 2;

   localparam logic [ExtWidth-1:0] OneE = ExtWidth'(1);
   // Half an LSB of the shifted result; evaluates to 0 when SHIFT == 0.
   localparam logic [ExtWidth-1:0] RoundConst = (OneE << SHIFT) >> 1;
   // Clip limits, held in ExtWidth-bit two's complement.
   localparam logic [ExtWidth-1:0] OutMax = (SIGNED != 0) ?
                                            (OneE << (OUTPUT_WIDTH - 1)) - OneE :
                                            (OneE << OUTPUT_WIDTH) - OneE;
   localparam logic [ExtWidth-1:0] OutMin = (SIGNED != 0) ?
                                            ExtWidth'(0) - (OneE << (OUTPUT_WIDTH - 1)) :
                                            ExtWidth'(0);

   // ---------------------------------------------------------------------------
   // Pipeline state
   // ---------------------------------------------------------------------------
   logic                    s1_valid_q;
   logic [INPUT_WIDTH-1:0]  s1_data_q;
   logic [COEFF_WIDTH-1:0]  s1_coeff_q;
   logic [TAG_WIDTH-1:0]    s1_tag_q;

   logic                    s2_valid_q;
   logic [ProdWidth-1:0]    s2_prod_q;
   logic [TAG_WIDTH-1:0]    s2_tag_q;

   logic                    s3_valid_q;
   logic [OUTPUT_WIDTH-1:0] s3_product_q;
   logic [TAG_WIDTH-1:0]    s3_tag_q;
   logic                    s3_sat_q;

   logic [COUNT_WIDTH-1:0]  sat_count_q;
   logic [COUNT_WIDTH-1:0]  sat_count_d;

   // ---------------------------------------------------------------------------
   // Flow control: a single global advance. Bubbles freeze too, which keeps
   // the stall logic to one signal and the outputs stable under backpressure.
   // ---------------------------------------------------------------------------
   logic advance;

   assign advance    = !s3_valid_q || out_ready_i;
   assign in_ready_o = advance;

   // ---------------------------------------------------------------------------
   // S1 input: coefficient select. Indices with no table entry leave 0.
   // ---------------------------------------------------------------------------
   logic [COEFF_WIDTH-1:0] coeff_sel;

   always_comb begin
      coeff_sel = '0;
      for (int unsigned k = 0; k < NUM_COEFFS; k++) begin
         if (k == 32'(coeff_idx_i)) begin
            coeff_sel = COEFFS[k*COEFF_WIDTH +: COEFF_WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // S2 input: multiply. Both operands are extended to the full product width;
   // the low ProdWidth bits of that product are exact for signed and unsigned
   // operands alike, so one unsigned multiplier serves both builds.
   // ---------------------------------------------------------------------------
   logic [ProdWidth-1:0] mul_a;
   logic [ProdWidth-1:0] mul_b;
   logic [ProdWidth-1:0] mul_p;

   always_comb begin
      if (SIGNED != 0) begin
         mul_a = {{COEFF_WIDTH{s1_data_q[INPUT_WIDTH-1]}}, s1_data_q};
         mul_b = {{INPUT_WIDTH{s1_coeff_q[COEFF_WIDTH-1]}}, s1_coeff_q};
      end else begin
         mul_a = {{COEFF_WIDTH{1'b0}}, s1_data_q};
         mul_b = {{INPUT_WIDTH{1'b0}}, s1_coeff_q};
      end
      mul_p = mul_a * mul_b;
   end

   // ---------------------------------------------------------------------------
   // S3 input: round half-up, arithmetic shift, saturate.
   // ---------------------------------------------------------------------------
   logic [ExtWidth-1:0]     prod_ext;
   logic [ExtWidth-1:0]     rounded;
   logic [ExtWidth-1:0]     shifted;
   logic [OUTPUT_WIDTH-1:0] clip_val;
   logic                    clip_sat;

   always_comb begin
      if (SIGNED != 0) begin
         prod_ext = {{2{s2_prod_q[ProdWidth-1]}}, s2_prod_q};
      end else begin
         prod_ext = {2'b00, s2_prod_q};
      end
      rounded = prod_ext + RoundConst;
      // Unsigned builds are never negative here, so >>> is also correct there.
      shifted  = $signed(rounded) >>> SHIFT;
      clip_val = shifted[OUTPUT_WIDTH-1:0];
      clip_sat = 1'b0;
      if ($signed(shifted) > $signed(OutMax)) begin
         clip_val = OutMax[OUTPUT_WIDTH-1:0];
         clip_sat = 1'b1;
      end else if ($signed(shifted) < $signed(OutMin)) begin
         clip_val = OutMin[OUTPUT_WIDTH-1:0];
         clip_sat = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Saturation event counter: counts clipped results actually delivered,
   // sticks at all-ones, clear has priority.
   // ---------------------------------------------------------------------------
   always_comb begin
      sat_count_d = sat_count_q;
      if (clear_i) begin
         sat_count_d = '0;
      end else if (s3_valid_q && out_ready_i && s3_sat_q && (sat_count_q != '1)) begin
         sat_count_d = sat_count_q + COUNT_WIDTH'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_coeff_q   <= '0;
         s1_tag_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_prod_q    <= '0;
         s2_tag_q     <= '0;
         s3_valid_q   <= 1'b0;
         s3_product_q <= '0;
         s3_tag_q     <= '0;
         s3_sat_q     <= 1'b0;
         sat_count_q  <= '0;
      end else begin
         if (advance) begin
            // S1 valid follows in_valid_i directly: advance is in_ready_o.
            s1_valid_q   <= in_valid_i;
            s1_data_q    <= data_i;
            s1_coeff_q   <= coeff_sel;
            s1_tag_q     <= tag_i;
            s2_valid_q   <= s1_valid_q;
            s2_prod_q    <= mul_p;
            s2_tag_q     <= s1_tag_q;
            s3_valid_q   <= s2_valid_q;
            s3_product_q <= clip_val;
            s3_tag_q     <= s2_tag_q;
            s3_sat_q     <= clip_sat;
         end
         sat_count_q <= sat_count_d;
      end
   end

   assign out_valid_o = s3_valid_q;
   assign product_o   = s3_product_q;
   assign tag_o       = s3_tag_q;
   assign sat_o       = s3_sat_q;
   assign sat_count_o = sat_count_q;

endmodule
